// File: rtl/char_blit_if.sv
// Bundle of the blitter's request, status, character-ROM and frame-buffer write signals.
// The master side is the environment: the requester and the ROM.
// The slave side is the blitter.
interface char_blit_if #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned COL_BITS   = 5,
  parameter int unsigned ROW_BITS   = 5
);
  localparam int unsigned AW = COL_BITS + ROW_BITS + 6;

  logic                  start;
  logic [7:0]            char_code;
  logic [COL_BITS-1:0]   col;
  logic [ROW_BITS-1:0]   row;
  logic [DATA_WIDTH-1:0] fg;
  logic [DATA_WIDTH-1:0] bg;
  logic                  transparent;
  logic                  busy;
  logic                  done;
  logic [10:0]           crom_adr;
  logic [7:0]            crom_q;
  logic [AW-1:0]         vram_wadr;
  logic [DATA_WIDTH-1:0] vram_d;
  logic                  vram_we;

  modport master (
    output start, char_code, col, row, fg, bg, transparent, crom_q,
    input  busy, done, crom_adr, vram_wadr, vram_d, vram_we
  );

  modport slave (
    input  start, char_code, col, row, fg, bg, transparent, crom_q,
    output busy, done, crom_adr, vram_wadr, vram_d, vram_we
  );
endinterface

// File: rtl/char_blit.sv
// Character-cell blitter.
// It fetches 8 glyph rows from a registered ROM and writes the 64 expanded pixels into one
// 8x8 text cell of a 256x256 frame buffer. Every output comes straight from a register.
module char_blit #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned COL_BITS   = 5,
  parameter int unsigned ROW_BITS   = 5
) (
  input  logic      CLOCK_50,
  input  logic      reset,
  char_blit_if.slave bus
);
  localparam int unsigned AW = COL_BITS + ROW_BITS + 6;

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [7:0]            code_q, code_d;
  logic [COL_BITS-1:0]   col_q, col_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [DATA_WIDTH-1:0] fg_q, fg_d;
  logic [DATA_WIDTH-1:0] bg_q, bg_d;
  logic                  transp_q, transp_d;
  logic [2:0]            grow_q, grow_d;
  logic [2:0]            px_q, px_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         wadr_q, wadr_d;
  logic [DATA_WIDTH-1:0] vd_q, vd_d;
  logic [10:0]           cadr_q, cadr_d;

  logic                  emit;
  logic                  pix_bit;
  logic [2:0]            pix_x;

  // Next-state and registered-output logic. A pixel is "emitted" on the edge that precedes
  // the cycle in which it is shown on the vram port.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    col_d    = col_q;
    row_d    = row_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    transp_d = transp_q;
    grow_d   = grow_q;
    px_d     = px_q;
    shreg_d  = shreg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    wadr_d   = wadr_q;
    vd_d     = vd_q;
    cadr_d   = cadr_q;
    emit     = 1'b0;
    pix_bit  = 1'b0;
    pix_x    = 3'd0;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          code_d   = bus.char_code;
          col_d    = bus.col;
          row_d    = bus.row;
          fg_d     = bus.fg;
          bg_d     = bus.bg;
          transp_d = bus.transparent;
          grow_d   = 3'd0;
          px_d     = 3'd0;
          cadr_d   = {bus.char_code, 3'd0};
          busy_d   = 1'b1;
          state_d  = StFetch;
        end else begin
          state_d = StIdle;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        // Pixel 0 comes directly from the ROM word; the remaining bits go to the shifter.
        shreg_d = {bus.crom_q[6:0], 1'b0};
        pix_bit = bus.crom_q[7];
        pix_x   = 3'd0;
        emit    = 1'b1;
        px_d    = 3'd0;
        state_d = StWrite;
      end
      StWrite: begin
        if (px_q != 3'd7) begin
          shreg_d = {shreg_q[6:0], 1'b0};
          pix_bit = shreg_q[7];
          pix_x   = px_q + 3'd1;
          emit    = 1'b1;
          px_d    = pix_x;
        end else if (grow_q != 3'd7) begin
          grow_d  = grow_q + 3'd1;
          cadr_d  = {code_q, grow_q + 3'd1};
          state_d = StFetch;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (emit) begin
      wadr_d = {row_q, grow_q, col_q, pix_x};
      vd_d   = pix_bit ? fg_q : bg_q;
      we_d   = pix_bit | ~transp_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StIdle;
      code_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      transp_q <= 1'b0;
      grow_q   <= '0;
      px_q     <= '0;
      shreg_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      wadr_q   <= '0;
      vd_q     <= '0;
      cadr_q   <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      transp_q <= transp_d;
      grow_q   <= grow_d;
      px_q     <= px_d;
      shreg_q  <= shreg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      wadr_q   <= wadr_d;
      vd_q     <= vd_d;
      cadr_q   <= cadr_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.crom_adr  = cadr_q;
  assign bus.vram_wadr = wadr_q;
  assign bus.vram_d    = vd_q;
  assign bus.vram_we   = we_q;
endmodule
